ysyx_24080006_mdu_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the RV32M subset.
- Accepts one decoded M-extension operation (the mdu_set_t bundle produced by decode) plus two operands through a valid/ready handshake.
- Runs a 32-step shift-add multiply or restoring divide, then holds the result until writeback accepts it.
- Sits between the EX-stage operand mux and the writeback arbiter, in parallel with the ALU. The EX stage stalls while in_ready or out_valid is pending.

---
 rtl/ysyx_24080006_pkg.sv | 36 +++
 rtl/ysyx_24080006_mdu_step.sv | 38 +++
 rtl/ysyx_24080006_mdu_ctrl.sv | 162 ++++++++++++++++
 tb/tb_ysyx_24080006_mdu_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080006_pkg.sv
// Shared decode types and MDU sequencer constants for the ysyx_24080006 core.
package ysyx_24080006_pkg;

  typedef enum logic [1:0] {
    ALU_MULL = 2'd0,
    ALU_MULH = 2'd1,
    ALU_DIV  = 2'd2,
    ALU_REM  = 2'd3
  } mdu_op_e;

  typedef struct packed {
    logic    mdu_enable;
    logic    signed_a;
    logic    signed_b;
    mdu_op_e mdu_op;
  } mdu_set_t;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  localparam logic [31:0] MDU_DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] MDU_OVF_Q  = 32'h8000_0000;

  // Magnitude of a possibly-signed operand; 0x80000000 maps to 2^31 unsigned.
  function automatic logic [31:0] mdu_mag(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic mdu_is_div(input mdu_op_e op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

endpackage

// File: rtl/ysyx_24080006_mdu_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
module ysyx_24080006_mdu_step
  import ysyx_24080006_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mdu_op_e             op,
  input  logic [2*XLEN-1:0]   acc,
  input  logic [XLEN-1:0]     opnd,
  output logic [2*XLEN-1:0]   acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] trial;
  logic [XLEN:0] diff;

  // Multiply: acc = {partial, multiplier}, shifted right each step.
  // Divide:   acc = {remainder, dividend/quotient}, shifted left each step.
  always_comb begin
    acc_next = acc;
    sum      = '0;
    trial    = '0;
    diff     = '0;
    if (mdu_is_div(op)) begin
      trial = acc[2*XLEN-1:XLEN-1];
      diff  = trial - {1'b0, opnd};
      if (!diff[XLEN]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ysyx_24080006_mdu_ctrl.sv
// Iterative RV32M multiply/divide sequencer with valid/ready in and out.
module ysyx_24080006_mdu_ctrl
  import ysyx_24080006_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  mdu_set_t        mdu_set,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  mdu_state_e        state;
  mdu_state_e        state_next;
  mdu_op_e           op;
  logic              sa;
  logic              sb;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo;
  logic [XLEN-1:0]   rem;
  logic [CNT_W-1:0]  counter;

  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   special_q;
  logic [XLEN-1:0]   final_q;
  logic              in_sa;
  logic              in_sb;
  logic              in_div;
  logic              div_zero;
  logic              div_ovf;
  logic              special;
  logic              accept;
  logic              last_iter;
  logic              consume;
  logic              unused_enable;

  assign unused_enable = mdu_set.mdu_enable;

  assign in_ready  = (state == MDU_IDLE);
  assign busy      = (state != MDU_IDLE);
  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = out_valid & out_ready;
  assign last_iter = (state == MDU_CALC) && (counter == CNT_W'(XLEN - 1));

  assign in_sa  = mdu_set.signed_a & src_a[XLEN-1];
  assign in_sb  = mdu_set.signed_b & src_b[XLEN-1];
  assign a_mag  = mdu_mag(src_a, in_sa);
  assign b_mag  = mdu_mag(src_b, in_sb);
  assign in_div = mdu_is_div(mdu_set.mdu_op);

  assign div_zero = in_div && (src_b == '0);
  assign div_ovf  = in_div && mdu_set.signed_a && mdu_set.signed_b &&
                    (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
  assign special  = div_zero | div_ovf;

  always_comb begin
    special_q = '0;
    if (div_zero) begin
      special_q = (mdu_set.mdu_op == ALU_DIV) ? MDU_DIV0_Q : src_a;
    end else begin
      special_q = (mdu_set.mdu_op == ALU_DIV) ? MDU_OVF_Q : '0;
    end
  end

  ysyx_24080006_mdu_step #(
    .XLEN(XLEN)
  ) u_step (
    .op      (op),
    .acc     (acc),
    .opnd    (opnd),
    .acc_next(acc_next)
  );

  // Sign fix-up works on the last step's output so it lands on the same edge.
  always_comb begin
    prod    = (sa ^ sb) ? (~acc_next + (2*XLEN)'(1)) : acc_next;
    quo     = (sa ^ sb) ? (~acc_next[XLEN-1:0] + XLEN'(1)) : acc_next[XLEN-1:0];
    rem     = sa ? (~acc_next[2*XLEN-1:XLEN] + XLEN'(1)) : acc_next[2*XLEN-1:XLEN];
    final_q = '0;
    unique case (op)
      ALU_MULL: final_q = prod[XLEN-1:0];
      ALU_MULH: final_q = prod[2*XLEN-1:XLEN];
      ALU_DIV:  final_q = quo;
      ALU_REM:  final_q = rem;
      default:  final_q = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = MDU_IDLE;
    end else begin
      unique case (state)
        MDU_IDLE: if (accept) state_next = special ? MDU_DONE : MDU_CALC;
        MDU_CALC: if (last_iter) state_next = MDU_DONE;
        MDU_DONE: if (consume) state_next = MDU_IDLE;
        default:  state_next = MDU_IDLE;
      endcase
    end
  end

  // out_valid trails entry into DONE by one edge, giving the special-case
  // one-cycle latency and the 33-cycle normal latency from the same rule.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= MDU_IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      out_valid <= (state == MDU_DONE) && (state_next == MDU_DONE);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op      <= ALU_MULL;
      sa      <= 1'b0;
      sb      <= 1'b0;
      opnd    <= '0;
      acc     <= '0;
      counter <= '0;
      result  <= '0;
    end else if (accept) begin
      op      <= mdu_set.mdu_op;
      sa      <= in_sa;
      sb      <= in_sb;
      counter <= '0;
      if (in_div) begin
        opnd <= b_mag;
        acc  <= {{XLEN{1'b0}}, a_mag};
      end else begin
        opnd <= a_mag;
        acc  <= {{XLEN{1'b0}}, b_mag};
      end
      if (special) begin
        result <= special_q;
      end
    end else if ((state == MDU_CALC) && !flush) begin
      acc <= acc_next;
      if (last_iter) begin
        result <= final_q;
      end else begin
        counter <= counter + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24080006_mdu_ctrl.sv
// Directed self-checking bench for the MDU sequencer with a cycle-level reference model.
module tb_ysyx_24080006_mdu_ctrl;
  import ysyx_24080006_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  mdu_set_t    mdu_set;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  bit          m_busy  = 1'b0;
  bit          m_valid = 1'b0;
  int          m_left  = 0;
  logic [31:0] m_res   = '0;

  ysyx_24080006_mdu_ctrl #(
    .XLEN (32),
    .CNT_W(5)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mdu_set  (mdu_set),
    .src_a    (src_a),
    .src_b    (src_b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] ref_res(input mdu_op_e op, input logic s_a, input logic s_b,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ea, eb, p;
    ea = s_a ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s_b ? {{32{b[31]}}, b} : {32'b0, b};
    p  = '0;
    case (op)
      ALU_MULL: begin p = ea * eb; return p[31:0]; end
      ALU_MULH: begin p = ea * eb; return p[63:32]; end
      ALU_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (s_a && s_b && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = ea / eb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        if (s_a && s_b && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = ea % eb;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input mdu_op_e op, input logic s_a, input logic s_b,
                                    input logic [31:0] a, input logic [31:0] b);
    if (op != ALU_DIV && op != ALU_REM) return 1'b0;
    return (b == 32'd0) || (s_a && s_b && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Model: transaction-level view of the handshake and latency.
  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0; m_valid = 1'b0; m_left = 0;
    end else if (flush) begin
      m_busy = 1'b0; m_valid = 1'b0; m_left = 0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy  = 1'b1;
        m_valid = 1'b0;
        m_res   = ref_res(mdu_set.mdu_op, mdu_set.signed_a, mdu_set.signed_b, src_a, src_b);
        m_left  = is_special(mdu_set.mdu_op, mdu_set.signed_a, mdu_set.signed_b, src_a, src_b) ? 1 : 33;
      end
    end else if (m_valid && out_ready) begin
      m_busy = 1'b0; m_valid = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_valid = 1'b1;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      chk("cmp_in_ready", {31'b0, in_ready}, {31'b0, !m_busy});
      chk("cmp_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cmp_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      if (m_valid) chk("cmp_result", result, m_res);
    end
  end

  task automatic offer(input mdu_op_e op, input logic s_a, input logic s_b,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    mdu_set.mdu_op     = op;
    mdu_set.signed_a   = s_a;
    mdu_set.signed_b   = s_b;
    mdu_set.mdu_enable = $urandom_range(0, 1);
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input mdu_op_e op, input logic s_a, input logic s_b,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    chk("pre_ready", {31'b0, in_ready}, 32'd1);
    offer(op, s_a, s_b, a, b);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("latency", lat, exp_lat);
    chk("value", result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_result", result, exp);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("drain_ready", {31'b0, in_ready}, 32'd1);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    mdu_set = '0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk_en = 1'b1;

    run_op(ALU_MULL, 1, 1, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 0);
    run_op(ALU_MULH, 1, 1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 0);
    run_op(ALU_MULH, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 0);
    run_op(ALU_MULH, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    run_op(ALU_DIV,  1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    run_op(ALU_REM,  1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    run_op(ALU_DIV,  0, 0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 0);
    run_op(ALU_REM,  0, 0, 32'hFFFF_FFF9, 32'd2, 32'd1, 33, 0);
    run_op(ALU_DIV,  1, 1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 0);
    run_op(ALU_REM,  1, 1, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, 0);
    run_op(ALU_DIV,  0, 0, 32'h8000_0000, 32'h8000_0000, 32'd1, 33, 0);
    run_op(ALU_DIV,  1, 1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    run_op(ALU_REM,  1, 1, 32'd5, 32'd0, 32'd5, 1, 0);
    run_op(ALU_DIV,  1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    run_op(ALU_REM,  1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
    run_op(ALU_MULL, 0, 0, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 33, 5);

    // Flush ten cycles into CALC
    offer(ALU_MULL, 0, 0, 32'd100, 32'd200);
    repeat (9) @(posedge clock);
    @(negedge clock); flush = 1'b1;
    @(posedge clock); #1; flush = 1'b0;
    chk("flush_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    repeat (40) @(posedge clock);
    #1 chk("flush_no_valid", {31'b0, out_valid}, 32'd0);
    run_op(ALU_MULL, 0, 0, 32'd3, 32'd4, 32'd12, 33, 0);

    // Flush together with in_valid in IDLE accepts nothing
    @(negedge clock);
    mdu_set.mdu_op = ALU_MULL; src_a = 32'd9; src_b = 32'd9;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clock); #1; in_valid = 1'b0; flush = 1'b0;
    chk("flush_in_idle_busy", {31'b0, busy}, 32'd0);
    chk("flush_in_idle_ready", {31'b0, in_ready}, 32'd1);

    // Flush beats out_ready in DONE
    offer(ALU_DIV, 1, 1, 32'd5, 32'd0);
    @(posedge clock); #1;
    chk("done_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clock); flush = 1'b1; out_ready = 1'b1;
    @(posedge clock); #1; flush = 1'b0; out_ready = 1'b0;
    chk("done_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("done_flush_ready", {31'b0, in_ready}, 32'd1);

    // Reset mid-CALC
    offer(ALU_DIV, 0, 0, 32'd1000, 32'd7);
    repeat (5) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_result", result, 32'd0);
    run_op(ALU_REM, 0, 0, 32'd1000, 32'd7, 32'd6, 33, 0);

    repeat (2) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
